// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide unit: operation codes and FSM state encoding.
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } mdu_state_t;

endpackage

// File: rtl/mdu_abs.sv
// Magnitude/sign split of an operand; unsigned operands pass through with sign=0.
module mdu_abs #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             is_signed,
    output logic [WIDTH-1:0] magnitude,
    output logic             sign
);

    assign sign      = is_signed & value[WIDTH-1];
    assign magnitude = sign ? -value : value;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit, one bit per cycle, results held in Hi/Lo.
// Handshake: Start is a request sampled only while Busy=0; Done is a one-cycle completion pulse.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic [2:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);

    mdu_state_t       state;
    logic [CW-1:0]    cnt;
    logic [2*WIDTH-1:0] work;
    logic [WIDTH-1:0] opnd;
    logic             is_div_q;
    logic             sign_a_q;
    logic             sign_b_q;
    logic             dz_q;

    logic             in_signed;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             sgn_a;
    logic             sgn_b;

    // MULT and DIV have Op[0]=0; the U variants take operands raw.
    assign in_signed = ~Op[0];

    mdu_abs #(.WIDTH(WIDTH)) u_abs_a (
        .value     (A),
        .is_signed (in_signed),
        .magnitude (mag_a),
        .sign      (sgn_a)
    );

    mdu_abs #(.WIDTH(WIDTH)) u_abs_b (
        .value     (B),
        .is_signed (in_signed),
        .magnitude (mag_b),
        .sign      (sgn_b)
    );

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_trial;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_rem;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix;
    logic [WIDTH-1:0]     rem_fix;
    logic [WIDTH-1:0]     fix_hi;
    logic [WIDTH-1:0]     fix_lo;

    // Multiplier sits in the low half and is consumed LSB-first as the accumulator shifts right.
    always_comb begin
        mul_sum = {1'b0, work[2*WIDTH-1:WIDTH]};
        if (work[0]) begin
            mul_sum = {1'b0, work[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        end
        mul_next = {mul_sum, work[WIDTH-1:1]};
    end

    // Partial remainder can briefly need WIDTH+1 bits after the shift, so the trial is one bit wider.
    always_comb begin
        div_shift = work[2*WIDTH-1:WIDTH-1];
        div_trial = div_shift - {1'b0, opnd};
        div_ge    = ~div_trial[WIDTH];
        div_rem   = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_next  = {div_rem, work[WIDTH-2:0], div_ge};
    end

    always_comb begin
        prod_fix = (sign_a_q ^ sign_b_q) ? -work : work;
        quot_fix = (sign_a_q ^ sign_b_q) ? -work[WIDTH-1:0] : work[WIDTH-1:0];
        rem_fix  = sign_a_q ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];
        fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = prod_fix[WIDTH-1:0];
        if (is_div_q) begin
            fix_hi = rem_fix;
            fix_lo = quot_fix;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            cnt      <= '0;
            work     <= '0;
            opnd     <= '0;
            is_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            dz_q     <= 1'b0;
            Hi       <= '0;
            Lo       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        sign_a_q <= sgn_a;
                        sign_b_q <= sgn_b;
                        is_div_q <= Op[1];
                        cnt      <= CW'(WIDTH);
                        if (Op[1]) begin
                            work <= {{WIDTH{1'b0}}, mag_a};
                            opnd <= mag_b;
                            if (B == '0) begin
                                dz_q  <= 1'b1;
                                state <= DONE;
                            end else begin
                                dz_q  <= 1'b0;
                                state <= DIV;
                            end
                        end else begin
                            work  <= {{WIDTH{1'b0}}, mag_b};
                            opnd  <= mag_a;
                            dz_q  <= 1'b0;
                            state <= MUL;
                        end
                    end
                end
                MUL: begin
                    work <= mul_next;
                    cnt  <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= FIX;
                    end
                end
                DIV: begin
                    work <= div_next;
                    cnt  <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    Hi    <= fix_hi;
                    Lo    <= fix_lo;
                    state <= DONE;
                end
                DONE: begin
                    dz_q  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Busy      = (state != IDLE);
    assign Done      = (state == DONE);
    assign DivZero   = (state == DONE) & dz_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomised scoreboard bench for mult_div_unit at WIDTH=32 and WIDTH=8.
module tb_mult_div_unit;

    localparam int W32 = 32;
    localparam int W8  = 8;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic           start32 = 1'b0, start8 = 1'b0;
    logic [1:0]     op32 = 2'b00, op8 = 2'b00;
    logic [W32-1:0] a32 = '0, b32 = '0;
    logic [W8-1:0]  a8 = '0, b8 = '0;
    logic           busy32, done32, dz32, busy8, done8, dz8;
    logic [W32-1:0] hi32, lo32;
    logic [W8-1:0]  hi8, lo8;
    logic [2:0]     st32, st8;

    mult_div_unit #(.WIDTH(W32)) dut32 (
        .Clk(clk), .Reset(rst_n), .Start(start32), .Op(op32), .A(a32), .B(b32),
        .Busy(busy32), .Done(done32), .DivZero(dz32), .Hi(hi32), .Lo(lo32), .dbg_state(st32)
    );

    mult_div_unit #(.WIDTH(W8)) dut8 (
        .Clk(clk), .Reset(rst_n), .Start(start8), .Op(op8), .A(a8), .B(b8),
        .Busy(busy8), .Done(done8), .DivZero(dz8), .Hi(hi8), .Lo(lo8), .dbg_state(st8)
    );

    // ---------------- scoreboard state ----------------
    typedef struct {
        logic [63:0] hi;
        logic [63:0] lo;
        logic        dz;
        int          done_edge;
        string       tag;
    } exp_t;

    exp_t        exp32_q[$];
    exp_t        exp8_q[$];
    exp_t        e32, e8;
    logic [63:0] m_hi[2];
    logic [63:0] m_lo[2];
    int          total = 0;
    int          bad   = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
        end
    endfunction

    function automatic void fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s (t=%0t)", name, $time);
    endfunction

    // Reference: plain integer arithmetic on sign-extended 64-bit values.
    function automatic exp_t model(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                                   input int w, input logic [63:0] phi, input logic [63:0] plo);
        exp_t        e;
        logic [63:0] mask;
        longint      sa, sb;
        logic [63:0] p;
        mask = (64'd1 << w) - 64'd1;
        sa = a[w-1] ? longint'(a | ~mask) : longint'(a);
        sb = b[w-1] ? longint'(b | ~mask) : longint'(b);
        e.hi = phi;
        e.lo = plo;
        e.dz = 1'b0;
        e.done_edge = 0;
        e.tag = "";
        case (op)
            2'b00: begin
                p = 64'(sa * sb);
                e.hi = (p >> w) & mask;
                e.lo = p & mask;
            end
            2'b01: begin
                p = a * b;
                e.hi = (p >> w) & mask;
                e.lo = p & mask;
            end
            2'b10: begin
                if (b == 64'd0) e.dz = 1'b1;
                else begin
                    e.lo = 64'(sa / sb) & mask;
                    e.hi = 64'(sa % sb) & mask;
                end
            end
            default: begin
                if (b == 64'd0) e.dz = 1'b1;
                else begin
                    e.lo = (a / b) & mask;
                    e.hi = (a % b) & mask;
                end
            end
        endcase
        return e;
    endfunction

    function automatic logic busy_of(input int sel);
        return (sel == 0) ? busy32 : busy8;
    endfunction

    function automatic logic [63:0] rand_val(input int w, input bit allow_zero);
        logic [63:0] mask;
        logic [63:0] v;
        mask = (64'd1 << w) - 64'd1;
        case ($urandom_range(0, 7))
            0: v = 64'd1 << (w - 1);
            1: v = mask;
            2: v = 64'($urandom_range(0, 15));
            3: v = allow_zero ? 64'd0 : 64'd3;
            default: v = {32'($urandom), 32'($urandom)};
        endcase
        return v & mask;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_idle(input int sel);
        int n;
        n = 0;
        @(negedge clk);
        while (busy_of(sel) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) fail_now("idle_timeout");
    endtask

    // Done is expected in cycle t+W+2 counted from the Start edge t, i.e. just after edge t+W+1.
    task automatic issue(input int sel, input logic [1:0] op, input logic [63:0] a_in,
                         input logic [63:0] b_in, input string tag);
        exp_t        e;
        int          w;
        logic [63:0] mask, a, b;
        w = (sel == 0) ? W32 : W8;
        mask = (64'd1 << w) - 64'd1;
        a = a_in & mask;
        b = b_in & mask;
        wait_idle(sel);
        e = model(op, a, b, w, m_hi[sel], m_lo[sel]);
        e.tag = tag;
        e.done_edge = cyc + 1 + (e.dz ? 0 : w + 1);
        if (!e.dz) begin
            m_hi[sel] = e.hi;
            m_lo[sel] = e.lo;
        end
        if (sel == 0) begin
            op32 = op; a32 = a[W32-1:0]; b32 = b[W32-1:0]; start32 = 1'b1;
            exp32_q.push_back(e);
        end else begin
            op8 = op; a8 = a[W8-1:0]; b8 = b[W8-1:0]; start8 = 1'b1;
            exp8_q.push_back(e);
        end
        @(negedge clk);
        start32 = 1'b0;
        start8  = 1'b0;
    endtask

    task automatic busy_window(input int sel, input string tag);
        int w, ok;
        w = (sel == 0) ? W32 : W8;
        ok = 0;
        for (int k = 0; k <= w; k++) begin
            if (sel == 0) ok += (busy32 && !done32) ? 1 : 0;
            else          ok += (busy8 && !done8) ? 1 : 0;
            if (k < w) @(negedge clk);
        end
        check(tag, 64'(ok), 64'(w + 1));
    endtask

    task automatic expect_hl(input int sel, input logic [63:0] hi, input logic [63:0] lo, input string tag);
        wait_idle(sel);
        check({tag, "_hi"}, (sel == 0) ? 64'(hi32) : 64'(hi8), hi);
        check({tag, "_lo"}, (sel == 0) ? 64'(lo32) : 64'(lo8), lo);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (rst_n && done32) begin
            if (exp32_q.size() == 0) fail_now("unexpected_done32");
            else begin
                e32 = exp32_q.pop_front();
                check({e32.tag, "_hi"}, 64'(hi32), e32.hi);
                check({e32.tag, "_lo"}, 64'(lo32), e32.lo);
                check({e32.tag, "_dz"}, 64'(dz32), 64'(e32.dz));
                check({e32.tag, "_lat"}, 64'(cyc), 64'(e32.done_edge));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && done8) begin
            if (exp8_q.size() == 0) fail_now("unexpected_done8");
            else begin
                e8 = exp8_q.pop_front();
                check({e8.tag, "_hi"}, 64'(hi8), e8.hi);
                check({e8.tag, "_lo"}, 64'(lo8), e8.lo);
                check({e8.tag, "_dz"}, 64'(dz8), 64'(e8.dz));
                check({e8.tag, "_lat"}, 64'(cyc), 64'(e8.done_edge));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        m_hi[0] = '0; m_lo[0] = '0; m_hi[1] = '0; m_lo[1] = '0;
        repeat (3) @(negedge clk);
        check("rst_busy32", 64'(busy32), 64'd0);
        check("rst_done32", 64'(done32), 64'd0);
        check("rst_dz32", 64'(dz32), 64'd0);
        check("rst_hi32", 64'(hi32), 64'd0);
        check("rst_lo32", 64'(lo32), 64'd0);
        check("rst_busy8", 64'(busy8), 64'd0);
        check("rst_hilo8", {32'(hi8), 32'(lo8)}, 64'd0);
        rst_n = 1'b1;

        // Directed cases at WIDTH=32
        issue(0, 2'b01, 64'hFFFF_FFFF, 64'hFFFF_FFFF, "multu_max");
        busy_window(0, "busy_window32");
        expect_hl(0, 64'hFFFF_FFFE, 64'h0000_0001, "multu_max_chk");
        issue(0, 2'b00, 64'hFFFF_FFFD, 64'd7, "mult_m3x7");
        expect_hl(0, 64'hFFFF_FFFF, 64'hFFFF_FFEB, "mult_m3x7_chk");
        issue(0, 2'b00, 64'hFFFF_FFFC, 64'hFFFF_FFFB, "mult_m4xm5");
        expect_hl(0, 64'h0, 64'h14, "mult_m4xm5_chk");
        issue(0, 2'b10, 64'hFFFF_FFF9, 64'd2, "div_m7d2");
        expect_hl(0, 64'hFFFF_FFFF, 64'hFFFF_FFFD, "div_m7d2_chk");
        issue(0, 2'b11, 64'd7, 64'd2, "divu_7d2");
        expect_hl(0, 64'd1, 64'd3, "divu_7d2_chk");
        issue(0, 2'b10, 64'h8000_0000, 64'hFFFF_FFFF, "div_minneg");
        expect_hl(0, 64'h0, 64'h8000_0000, "div_minneg_chk");

        // Divide by zero keeps the preloaded Hi=5/Lo=9
        issue(0, 2'b11, 64'd95, 64'd10, "preload");
        issue(0, 2'b11, 64'd10, 64'd0, "divu_by0");
        @(negedge clk);
        check("by0_back_idle", 64'(busy32), 64'd0);
        expect_hl(0, 64'd5, 64'd9, "by0_hold");

        // Second Start and operand change mid-operation are ignored
        issue(0, 2'b01, 64'd6, 64'd7, "multu_6x7");
        repeat (4) @(negedge clk);
        start32 = 1'b1; a32 = 32'd100; b32 = 32'd100;
        @(negedge clk);
        start32 = 1'b0;
        expect_hl(0, 64'd0, 64'd42, "ignored_start");

        // Reset in the middle of a divide
        issue(0, 2'b10, 64'd1000, 64'd7, "div_aborted");
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy32), 64'd0);
        check("abort_hilo", {32'(hi32), 32'(lo32)}, 64'd0);
        exp32_q.delete();
        exp8_q.delete();
        m_hi[0] = '0; m_lo[0] = '0; m_hi[1] = '0; m_lo[1] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        issue(0, 2'b01, 64'd3, 64'd3, "multu_3x3");
        expect_hl(0, 64'd0, 64'd9, "post_reset_chk");

        // Random traffic at WIDTH=32
        for (int i = 0; i < 40; i++) begin
            logic [1:0] op;
            op = 2'($urandom_range(0, 3));
            issue(0, op, rand_val(W32, 1'b0), rand_val(W32, 1'b1), "rand32");
        end

        // Directed and random traffic at WIDTH=8
        issue(1, 2'b01, 64'hFF, 64'hFF, "multu8_max");
        busy_window(1, "busy_window8");
        expect_hl(1, 64'hFE, 64'h01, "multu8_max_chk");
        issue(1, 2'b00, 64'hFD, 64'd7, "mult8_m3x7");
        expect_hl(1, 64'hFF, 64'hEB, "mult8_m3x7_chk");
        issue(1, 2'b10, 64'hF9, 64'd2, "div8_m7d2");
        expect_hl(1, 64'hFF, 64'hFD, "div8_m7d2_chk");
        issue(1, 2'b10, 64'h80, 64'hFF, "div8_minneg");
        expect_hl(1, 64'h00, 64'h80, "div8_minneg_chk");
        for (int i = 0; i < 40; i++) begin
            logic [1:0] op;
            op = 2'($urandom_range(0, 3));
            issue(1, op, rand_val(W8, 1'b0), rand_val(W8, 1'b1), "rand8");
        end

        // Drain and final hold checks
        begin
            int n;
            n = 0;
            while ((exp32_q.size() != 0 || exp8_q.size() != 0) && n < 500) begin
                @(negedge clk);
                n++;
            end
        end
        check("drain32", 64'(exp32_q.size()), 64'd0);
        check("drain8", 64'(exp8_q.size()), 64'd0);
        repeat (3) @(negedge clk);
        check("hold_hi32", 64'(hi32), m_hi[0]);
        check("hold_lo32", 64'(lo32), m_lo[0]);
        check("hold_hi8", 64'(hi8), m_hi[1]);
        check("hold_lo8", 64'(lo8), m_lo[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
